// File: rtl/config_write_arbiter.sv
// Round-robin write arbiter for the five-entry configuration register bank.
// One grant per IDLE->COMMIT pass; the bank is written on the edge that closes COMMIT.
module config_write_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              wr_err,
  output logic              busy
);
  localparam int NUM_REQ  = 2;
  localparam int NUM_REGS = 5;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  typedef enum logic {IDLE, COMMIT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t [NUM_REQ-1:0] req;
  logic    [NUM_REQ-1:0] req_valid;
  logic                  win;

  state_e                               state_q, state_d;
  wr_req_t                              hold_q, hold_d;
  logic    [NUM_REQ-1:0]                ready_q, ready_d;
  logic                                 wr_err_q, wr_err_d;
  logic                                 last_grant_q, last_grant_d;
  logic    [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;

  assign req[0]    = {req0_addr, req0_data};
  assign req[1]    = {req1_addr, req1_data};
  assign req_valid = {req1_valid, req0_valid};

  // A tie goes to whoever was not granted last; otherwise the lone requester wins.
  assign win = (&req_valid) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    ready_d      = ready_q;
    wr_err_d     = wr_err_q;
    last_grant_d = last_grant_q;
    regs_d       = regs_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          hold_d       = req[win];
          last_grant_d = win;
          ready_d      = '0;
          ready_d[win] = 1'b1;
          wr_err_d     = (req[win].addr >= NUM_REGS_A);
          state_d      = COMMIT;
        end
      end
      COMMIT: begin
        if (hold_q.addr < NUM_REGS_A)
          regs_d[hold_q.addr[2:0]] = hold_q.data;
        ready_d  = '0;
        wr_err_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      ready_q      <= '0;
      wr_err_q     <= 1'b0;
      last_grant_q <= 1'b1;
      regs_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      ready_q      <= ready_d;
      wr_err_q     <= wr_err_d;
      last_grant_q <= last_grant_d;
      regs_q       <= regs_d;
    end
  end

  assign req0_ready      = ready_q[0];
  assign req1_ready      = ready_q[1];
  assign wr_err          = wr_err_q;
  assign busy            = (state_q == COMMIT);
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_config_write_arbiter.sv
// Bench for config_write_arbiter: queue-fed requester agents, a transaction-level
// reference model compared every cycle, and directed literal checks.
module tb_config_write_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0, v1;
  logic [6:0] a0, a1;
  logic [7:0] d0, d1;
  logic       r0, r1, wr_err, busy;
  logic [7:0] o0, o1, p0, p1, duty;

  always #5 clk = ~clk;

  config_write_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .en_reg_out_7_0(o0), .en_reg_out_15_8(o1),
    .en_reg_pwm_7_0(p0), .en_reg_pwm_15_8(p1),
    .pwm_duty_cycle(duty), .wr_err(wr_err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  bit done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one pending write at a time ----------------
  logic [7:0] m_regs [5];
  logic       m_pend, m_id, m_last;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_win;
  assign m_win = (v0 && v1) ? !m_last : v1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_last <= 1'b1;
      m_id   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      for (int i = 0; i < 5; i++) m_regs[i] <= 8'h00;
    end else if (m_pend) begin
      if (m_addr < 7'd5) m_regs[m_addr] <= m_data;
      m_pend <= 1'b0;
    end else if (v0 || v1) begin
      m_pend <= 1'b1;
      m_id   <= m_win;
      m_last <= m_win;
      m_addr <= m_win ? a1 : a0;
      m_data <= m_win ? d1 : d0;
    end
  end

  // ---------------- requester agents ----------------
  typedef struct packed { logic [6:0] a; logic [7:0] d; } txn_t;
  txn_t q0[$];
  txn_t q1[$];
  logic [1:0] prev_rdy;

  initial begin
    txn_t t;
    v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v0 = 0; v1 = 0; prev_rdy = 0;
      end else begin
        if (v0 && prev_rdy[0]) v0 = 0;
        if (v1 && prev_rdy[1]) v1 = 0;
        if (!v0 && q0.size() > 0) begin t = q0.pop_front(); a0 = t.a; d0 = t.d; v0 = 1; end
        if (!v1 && q1.size() > 0) begin t = q1.pop_front(); a1 = t.a; d1 = t.d; v1 = 1; end
        prev_rdy = {r1, r0};
      end
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int         glog[$];
  logic [7:0] plog[$];
  logic [7:0] duty_prev = 8'h00;
  int         err_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("ready0", r0, m_pend && !m_id);
        chk("ready1", r1, m_pend && m_id);
        chk("busy", busy, m_pend);
        chk("wr_err", wr_err, m_pend && (m_addr > 7'd4));
        chk("one_ready", r0 && r1, 1'b0);
        chk("reg0", o0, m_regs[0]);
        chk("reg1", o1, m_regs[1]);
        chk("reg2", p0, m_regs[2]);
        chk("reg3", p1, m_regs[3]);
        chk("reg4", duty, m_regs[4]);
        if (r0) glog.push_back(0);
        if (r1) glog.push_back(1);
        if (wr_err) err_cnt++;
        if (duty !== duty_prev) plog.push_back(duty);
        duty_prev = duty;
      end
    end
  end

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #3;
      if (q0.size() == 0 && q1.size() == 0 && !v0 && !v1 && !busy) begin ok = 1; break; end
    end
    chk({nm, "_idle_timeout"}, ok, 1'b1);
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.a = ($urandom_range(9) == 0) ? 7'($urandom) : 7'($urandom_range(5));
    t.d = 8'($urandom);
    return t;
  endfunction

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // reset in the middle of a COMMIT discards the write
    q0.push_back('{a: 7'h04, d: 8'hAA});
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (r0) begin ok = 1; break; end
    end
    chk("rst_setup_ready", ok, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_ready0", r0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_duty", duty, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    wait_idle("rst");
    chk("rst_duty_after", duty, 8'h00);

    // tie after reset: requester 0 first
    glog.delete();
    q0.push_back('{a: 7'h00, d: 8'h11});
    q1.push_back('{a: 7'h01, d: 8'h22});
    wait_idle("tie");
    chk("tie_n", glog.size(), 2);
    chk("tie_first", glog[0], 0);
    chk("tie_second", glog[1], 1);
    chk("tie_reg0", o0, 8'h11);
    chk("tie_reg1", o1, 8'h22);

    // fairness: both held for 8 writes each to the duty register
    glog.delete(); plog.delete();
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{a: 7'h04, d: 8'(8'h01 + i)});
      q1.push_back('{a: 7'h04, d: 8'(8'h81 + i)});
    end
    wait_idle("fair");
    chk("fair_n", glog.size(), 16);
    chk("fair_pwm_n", plog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("fair_grant", glog[i], i % 2);
      chk("fair_pwm", plog[i], (i % 2) ? 8'(8'h81 + i / 2) : 8'(8'h01 + i / 2));
    end

    // single write
    q0.push_back('{a: 7'h02, d: 8'h5A});
    wait_idle("single");
    chk("single_reg2", p0, 8'h5A);
    chk("single_reg3", p1, 8'h00);
    chk("single_reg0", o0, 8'h11);

    // unmapped addresses
    err_cnt = 0; glog.delete();
    q1.push_back('{a: 7'h05, d: 8'hFF});
    q1.push_back('{a: 7'h7F, d: 8'hFF});
    wait_idle("unmap");
    chk("unmap_err_cnt", err_cnt, 2);
    chk("unmap_grants", glog.size(), 2);
    chk("unmap_reg0", o0, 8'h11);
    chk("unmap_reg1", o1, 8'h22);
    chk("unmap_reg2", p0, 8'h5A);
    chk("unmap_reg3", p1, 8'h00);
    chk("unmap_reg4", duty, 8'h88);

    // same-register race with last grant on requester 0
    q0.push_back('{a: 7'h03, d: 8'h33});
    wait_idle("race_pre");
    glog.delete();
    q0.push_back('{a: 7'h03, d: 8'h0F});
    q1.push_back('{a: 7'h03, d: 8'hF0});
    wait_idle("race");
    chk("race_first", glog[0], 1);
    chk("race_second", glog[1], 0);
    chk("race_reg3", p1, 8'h0F);

    // randomized traffic checked by the model every cycle
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #3;
      if (q0.size() < 2 && $urandom_range(2) == 0) q0.push_back(rnd_txn());
      if (q1.size() < 2 && $urandom_range(2) == 0) q1.push_back(rnd_txn());
    end
    wait_idle("rand");

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_write_arbiter.md
# config_write_arbiter

Arbitrated write port for the chip's configuration register bank (output enables, PWM enables, PWM duty cycle). Two independent requesters share the bank: requester 0 is the SPI frame decoder and requester 1 is an on-chip sequencer (fade/test engine). The block grants one write at a time with round-robin fairness, commits it to the bank and acknowledges the winner. It owns the five configuration registers that drive the output-enable and PWM logic.

## Interface

Parameters:
- ADDR_W, 7, register address width
- DATA_W, 8, register data width

Ports:
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 write request
- req0_addr  input  ADDR_W  requester 0 register address
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 acknowledge; 1-cycle pulse
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- wr_err  output  1  1-cycle pulse: committed write targeted an unmapped address
- busy  output  1  high while in COMMIT

## Operation

- FSM states: IDLE, COMMIT. Reset state IDLE.
- IDLE: if no valid, stay. If any valid, pick a winner, latch its addr/data and id into holding registers, go to COMMIT, set winner's ready.
- Arbitration: one valid wins outright. Both valid: the requester not granted last wins. last_grant resets to 1, so requester 0 wins the first tie. last_grant updates on every grant.
- COMMIT: winner's ready = 1, busy = 1. On the closing edge, write the holding data to the addressed register, clear ready, return to IDLE. COMMIT lasts exactly one cycle. Inputs are not sampled in COMMIT.
- Address decode: 0x00–0x04 map to the registers above. 0x05–0x7F change no register. For these, wr_err is high during the COMMIT cycle and ready is still given.
- Requester protocol: hold valid/addr/data stable until ready is sampled high. The handshake completes on the edge that ends COMMIT. Change or drop valid after that edge.
- If a requester drops valid or changes data during COMMIT, that is a protocol violation. The latched values are still committed.
- A loser keeps valid asserted and is granted in the next IDLE cycle.
- Reset mid-operation: the asynchronous reset immediately clears the FSM to IDLE, all registers to 0x00, ready/wr_err/busy to 0 and last_grant to 1. A pending write is discarded.

## Timing

- Reset values: all five registers 0x00. req0_ready, req1_ready, wr_err and busy are 0.
- Latency: valid is sampled high at edge E0, in IDLE. ready/busy/wr_err are high from E0 to E1. The register holds its new value after E1.
- Throughput: one write per 2 cycles. Two requesters held continuously alternate grants: 0, 1, 0, 1…
- ready, wr_err and busy are registered outputs (no combinational path from inputs). At most one ready is high in any cycle.
- Register outputs change only on the edge ending COMMIT.

## Test plan

- Reset: assert rst_n=0 mid-COMMIT with req0 writing 0x04←0xAA -> all outputs 0, pwm_duty_cycle stays 0x00, FSM IDLE after release.
- Single write: req0 writes addr 0x02 data 0x5A -> req0_ready high exactly the cycle after sampling; en_reg_pwm_7_0=0x5A one edge later; other registers unchanged.
- Tie after reset: req0 (0x00←0x11) and req1 (0x01←0x22) valid together -> req0 granted first, req1 granted two cycles later; final en_reg_out_7_0=0x11, en_reg_out_15_8=0x22.
- Fairness: both requesters hold valid for 8 writes each, to address 0x04 with data 0x01.. and 0x81.. -> grants strictly alternate; pwm_duty_cycle follows the interleaved sequence; never both ready.
- Unmapped address: req1 writes 0x05←0xFF, then 0x7F←0xFF -> wr_err pulses with req1_ready each time; all registers unchanged.
- Same-register race: req0 0x03←0x0F and req1 0x03←0xF0 simultaneous, last_grant=0 -> req1 commits first, then req0; final en_reg_pwm_15_8=0x0F.
